mips_muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. Sits directly downstream of the register bank. It consumes the rs/rt values read on `rd1`/`rd2` for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It produces `hi`/`lo`, which the writeback mux forwards to `wd3` for MFHI/MFLO. One shift-add or restoring-divide step per clock, with a start/busy/done handshake toward the control unit.

---
 rtl/mips_muldiv_pkg.sv | 24 ++
 rtl/muldiv_sign_fix.sv | 15 +
 rtl/mips_muldiv.sv | 217 +++++++++++++++++++++
 tb/tb_mips_muldiv.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared types and constants for the multiply/divide unit.
//   muldiv_op_t    - op encodings seen on the op port (110/111 reserved)
//   muldiv_state_t - sequencer states
//   MULDIV_WIDTH   - default operand width
package mips_muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMthi  = 3'b100,
        OpMtlo  = 3'b101
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: combinational conditional two's-complement negate.
//   neg_i  - negate data_i when high, pass through otherwise
//   data_i - input value (Width bits)
//   data_o - result (Width bits)
module muldiv_sign_fix #(
    parameter int unsigned Width = 32
) (
    input  logic             neg_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o
);

    assign data_o = neg_i ? -data_i : data_i;

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring-divide step per clock over operand magnitudes,
// followed by a single sign-correction/writeback cycle.
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   start, op     - request and operation, sampled only while idle
//   a, b          - rs / rt operands, only needed in the start cycle
//   busy          - operation in flight
//   done          - one-cycle pulse after HI/LO are written
//   div0          - pulses with done on a divide by zero
//   hi, lo        - HI / LO registers
// Build option: define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are
// ignored like reserved ops and div0 is tied low.
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    muldiv_state_t        state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic                 neg_q, neg_d;     // operand signs differ on a signed op
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 is_mul_op, is_div_op, is_signed;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       add_sum;
    logic [2*WIDTH-1:0]   mul_next, prod_fixed;

    assign is_mul_op = (op == OpMult) || (op == OpMultu);
    assign is_signed = (op == OpMult) || (op == OpDiv);

    muldiv_sign_fix #(.Width(WIDTH)) u_mag_a (
        .neg_i  (is_signed & a[WIDTH-1]),
        .data_i (a),
        .data_o (mag_a)
    );

    muldiv_sign_fix #(.Width(WIDTH)) u_mag_b (
        .neg_i  (is_signed & b[WIDTH-1]),
        .data_i (b),
        .data_o (mag_b)
    );

    muldiv_sign_fix #(.Width(2*WIDTH)) u_fix_prod (
        .neg_i  (neg_q),
        .data_i (acc_q),
        .data_o (prod_fixed)
    );

    // Shift-add step: conditionally add multiplicand into the upper half, shift right.
    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic                 is_div_q, is_div_d;
    logic                 neg_rem_q, neg_rem_d;   // dividend was negative (signed)
    logic                 dz_q, dz_d;             // divisor was zero
    logic                 div0_q, div0_d;
    logic [WIDTH:0]       div_shift, div_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [WIDTH-1:0]     quot_fixed, rem_fixed;

    assign is_div_op = (op == OpDiv) || (op == OpDivu);

    // Restoring step: {remainder, next dividend bit} minus divisor; keep if no borrow.
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // With a zero divisor every step "subtracts", leaving quotient = all ones and
    // remainder = |a|; re-applying the dividend sign to |a| restores a unmodified.
    muldiv_sign_fix #(.Width(WIDTH)) u_fix_quot (
        .neg_i  (neg_q & ~dz_q),
        .data_i (acc_q[WIDTH-1:0]),
        .data_o (quot_fixed)
    );

    muldiv_sign_fix #(.Width(WIDTH)) u_fix_rem (
        .neg_i  (neg_rem_q),
        .data_i (acc_q[2*WIDTH-1:WIDTH]),
        .data_o (rem_fixed)
    );

    assign div0 = div0_q;
`else
    assign is_div_op = 1'b0;
    assign div0      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        div0_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_mul_op || is_div_op) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        opnd_d  = mag_b;
                        neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                        is_div_d  = is_div_op;
                        neg_rem_d = is_signed & a[WIDTH-1];
                        dz_d      = (b == '0);
`endif
                    end else if (op == OpMthi) begin
                        hi_d   = a;
                        done_d = 1'b1;
                    end else if (op == OpMtlo) begin
                        lo_d   = a;
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
`ifdef MULDIV_DIV_EN
                acc_d = is_div_q ? div_next : mul_next;
`else
                acc_d = mul_next;
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    hi_d   = rem_fixed;
                    lo_d   = quot_fixed;
                    div0_d = dz_q;
                end else begin
                    {hi_d, lo_d} = prod_fixed;
                end
`else
                {hi_d, lo_d} = prod_fixed;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            div0_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            div0_q    <= div0_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: directed self-checking bench for mips_muldiv.
// Divide vectors run when MULDIV_DIV_EN is defined; otherwise DIV is checked as ignored.
module tb_mips_muldiv;
    import mips_muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op    = 3'b000;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy, done, div0;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_pass   = 0;

    mips_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Present a request for one cycle; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'b111;
        a     = 32'hA5A5_A5A5;
        b     = 32'h5A5A_5A5A;
    endtask

    // Count cycles with busy high; bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] eh,
                          input logic [W-1:0] el, input logic ed0);
        int cyc;
        issue(o, x, y);
        wait_done(cyc);
        check({tag, " busy_cycles"}, 64'(cyc), 64'(W + 1));
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        check({tag, " div0"}, 64'(div0), 64'(ed0));
    endtask

    initial begin
        int cyc;
        logic [W-1:0] hold_hi, hold_lo;

        // Reset state
        #3;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst div0", 64'(div0), 64'd0);
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned max*max, then done must drop after one cycle
        run_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(posedge clk);
        #1;
        check("multu_max done_drop", 64'(done), 64'd0);

        // Signed multiply, then back-to-back MULTU issued in the done cycle
        run_op("mult_neg", OpMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("multu_b2b", OpMultu, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

`ifdef MULDIV_DIV_EN
        run_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu", OpDivu, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_op("divu_zero", OpDivu, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #1;
        check("divu_zero div0_drop", 64'(div0), 64'd0);
`else
        // Without the divider, DIV is ignored like a reserved op
        issue(OpDiv, 32'd7, 32'd2);
        check("div_off busy", 64'(busy), 64'd0);
        check("div_off done", 64'(done), 64'd0);
        check("div_off hi", 64'(hi), 64'd0);
        check("div_off lo", 64'(lo), 64'd6);
`endif

        // MTHI / MTLO
        issue(OpMthi, 32'h1234_5678, 32'd0);
        check("mthi hi", 64'(hi), 64'h1234_5678);
        check("mthi done", 64'(done), 64'd1);
        check("mthi busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("mthi done_drop", 64'(done), 64'd0);
        check("mthi busy_after", 64'(busy), 64'd0);
        hold_lo = lo;
        issue(OpMtlo, 32'hCAFE_BABE, 32'd0);
        check("mtlo lo", 64'(lo), 64'hCAFE_BABE);
        check("mtlo hi_kept", 64'(hi), 64'h1234_5678);
        check("mtlo done", 64'(done), 64'd1);
        check("mtlo prev_lo", 64'(hold_lo == 32'hCAFE_BABE), 64'd0);

        // Reserved op: no state change, no done
        issue(3'b110, 32'h1111_1111, 32'h2222_2222);
        check("rsvd busy", 64'(busy), 64'd0);
        check("rsvd done", 64'(done), 64'd0);
        check("rsvd hi", 64'(hi), 64'h1234_5678);
        check("rsvd lo", 64'(lo), 64'hCAFE_BABE);

        // start pulsed mid-MULT must be ignored and must not restart the count
        issue(OpMult, 32'h0001_0001, 32'h0001_0001);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        hold_hi = hi;
        issue(OpMthi, 32'hDEAD_BEEF, 32'd0);
        check("mid_start hi_hold", 64'(hi), 64'(hold_hi));
        wait_done(cyc);
        check("mid_start busy_left", 64'(cyc), 64'(W + 1 - 6));
        check("mid_start done", 64'(done), 64'd1);
        check("mid_start hi", 64'(hi), 64'h0000_0001);
        check("mid_start lo", 64'(lo), 64'h0002_0001);

        // Asynchronous reset mid-operation, checked before any clock edge
        issue(OpMult, 32'd9, 32'd9);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst busy", 64'(busy), 64'd0);
        check("async_rst done", 64'(done), 64'd0);
        check("async_rst hi", 64'(hi), 64'd0);
        check("async_rst lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("multu_after_rst", OpMultu, 32'd4, 32'd5, 32'd0, 32'd20, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
